// File: rtl/alu_status_flags.sv
// Registered N/Z/C/V status flags for the ALU result path, with sticky copies
// and a saturating overflow-event counter. Arithmetic flags are gated per opcode.
module alu_status_flags #(
  parameter int                  WIDTH       = 4,
  parameter int                  OP_W        = 3,
  parameter logic [2**OP_W-1:0]  ARITH_MASK  = 8'b0110_0011,
  parameter int                  SIGNED_MODE = 1,
  parameter int                  CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] result,
  input  logic             carry_in,
  input  logic             ovf_in,
  input  logic             hold,
  input  logic             clear_sticky,
  output logic             negative,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             sticky_n,
  output logic             sticky_z,
  output logic             sticky_c,
  output logic             sticky_v,
  output logic             flags_valid,
  output logic [CNT_W-1:0] ovf_count
);

  localparam logic             SIGNED_EN = (SIGNED_MODE != 0);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  logic             arith;
  logic             accept;
  logic             nxt_n, nxt_z, nxt_c, nxt_v;
  logic [3:0]       sticky_base;
  logic [3:0]       sticky_nxt;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W-1:0] cnt_nxt;

  assign arith  = ARITH_MASK[op];
  assign accept = valid_in & ~hold;

  assign nxt_n = arith & SIGNED_EN & result[WIDTH-1];
  assign nxt_z = (result == '0);
  assign nxt_c = arith & carry_in;
  assign nxt_v = arith & ovf_in;

  // Clear takes effect before the same-cycle event is folded in.
  always_comb begin
    sticky_base = clear_sticky ? 4'b0000 : {sticky_n, sticky_z, sticky_c, sticky_v};
    cnt_base    = clear_sticky ? '0 : ovf_count;
    sticky_nxt  = sticky_base;
    cnt_nxt     = cnt_base;
    if (valid_in) begin
      sticky_nxt = sticky_base | {nxt_n, nxt_z, nxt_c, nxt_v};
      if (nxt_v && (cnt_base != CNT_MAX)) begin
        cnt_nxt = cnt_base + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      negative    <= 1'b0;
      zero        <= 1'b0;
      carry       <= 1'b0;
      overflow    <= 1'b0;
      sticky_n    <= 1'b0;
      sticky_z    <= 1'b0;
      sticky_c    <= 1'b0;
      sticky_v    <= 1'b0;
      flags_valid <= 1'b0;
      ovf_count   <= '0;
    end else if (!hold) begin
      flags_valid <= accept;
      {sticky_n, sticky_z, sticky_c, sticky_v} <= sticky_nxt;
      ovf_count   <= cnt_nxt;
      if (accept) begin
        negative <= nxt_n;
        zero     <= nxt_z;
        carry    <= nxt_c;
        overflow <= nxt_v;
      end
    end
  end

endmodule
